dbus_ram_io: RTL and testbench

Data-bus responder for the bittyCore DE10-Lite build. It sits on the memory-access stage's data port, serves word-addressed data RAM with byte-lane writes, and exposes memory-mapped LEDs, synchronized slide switches and a compare-match timer with an interrupt. Reads are combinational, so load data is available in the same cycle as the access; all state changes happen on the clock edge.

---
 rtl/dbus_ram_io.sv | 132 +++++++++++++
 tb/tb_dbus_ram_io.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dbus_ram_io.sv
// Data-bus responder: word-addressed RAM with byte-lane writes, LEDs, synchronized
// switches and a compare-match timer. Reads are combinational, writes take effect at the edge.
module dbus_ram_io #(
  parameter int unsigned RAM_AW     = 10,
  parameter logic [3:0]  IO_BASE_HI = 4'h4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  input  logic [9:0]  sw_i,
  output logic [9:0]  led_o,
  output logic        timer_irq_o
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

  localparam logic [2:0] OFF_LED  = 3'd0;
  localparam logic [2:0] OFF_SW   = 3'd1;
  localparam logic [2:0] OFF_CNT  = 3'd2;
  localparam logic [2:0] OFF_CMP  = 3'd3;
  localparam logic [2:0] OFF_CTRL = 3'd4;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

  logic [31:0]       ram [RAM_DEPTH];
  logic              sel_ram, sel_io, rd_en, ram_wr, io_wr;
  logic [RAM_AW-1:0] ram_idx;
  logic [2:0]        io_off;

  logic [9:0]  led_q;
  logic [9:0]  sw_meta, sw_sync;
  logic [31:0] cnt_q, cmp_q, cnt_run;
  logic        ctrl_en, ctrl_pend, ctrl_ar, ctrl_ie;
  logic        match, led_wr, cnt_wr, cmp_wr, ctrl_lo_wr, pend_clr;
  logic        unused_addr;

  assign sel_ram = (mem_addr_i[31:28] == 4'h0);
  assign sel_io  = (mem_addr_i[31:28] == IO_BASE_HI);
  assign rd_en   = mem_ce_i & ~mem_we_i;
  assign ram_wr  = mem_ce_i & mem_we_i & sel_ram;
  assign io_wr   = mem_ce_i & mem_we_i & sel_io;
  assign ram_idx = mem_addr_i[RAM_AW+1:2];
  assign io_off  = mem_addr_i[4:2];
  assign unused_addr = ^mem_addr_i[27:0];

  assign led_wr     = io_wr & (io_off == OFF_LED);
  assign cnt_wr     = io_wr & (io_off == OFF_CNT);
  assign cmp_wr     = io_wr & (io_off == OFF_CMP);
  assign ctrl_lo_wr = io_wr & (io_off == OFF_CTRL) & mem_sel_i[0];
  assign pend_clr   = ctrl_lo_wr & mem_data_i[1];

  // Match only counts while running; auto-reload replaces the increment on a match.
  assign match = ctrl_en & (cnt_q == cmp_q);

  always_comb begin
    cnt_run = cnt_q;
    if (ctrl_en) begin
      cnt_run = (match && ctrl_ar) ? 32'd0 : cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_sel_i[i]) ram[ram_idx][8*i +: 8] <= mem_data_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      led_q     <= '0;
      sw_meta   <= '0;
      sw_sync   <= '0;
      cnt_q     <= '0;
      cmp_q     <= 32'hFFFF_FFFF;
      ctrl_en   <= 1'b0;
      ctrl_pend <= 1'b0;
      ctrl_ar   <= 1'b0;
      ctrl_ie   <= 1'b0;
    end else begin
      sw_meta <= sw_i;
      sw_sync <= sw_meta;
      if (led_wr && mem_sel_i[0]) led_q[7:0] <= mem_data_i[7:0];
      if (led_wr && mem_sel_i[1]) led_q[9:8] <= mem_data_i[9:8];
      // Software lanes override the running value; untouched lanes keep counting.
      cnt_q <= cnt_wr ? lane_merge(cnt_run, mem_data_i, mem_sel_i) : cnt_run;
      if (cmp_wr) cmp_q <= lane_merge(cmp_q, mem_data_i, mem_sel_i);
      if (ctrl_lo_wr) begin
        ctrl_en <= mem_data_i[0];
        ctrl_ar <= mem_data_i[2];
        ctrl_ie <= mem_data_i[3];
      end
      // A new match beats a same-cycle clear.
      if (match)         ctrl_pend <= 1'b1;
      else if (pend_clr) ctrl_pend <= 1'b0;
    end
  end

  always_comb begin
    mem_data_o = '0;
    if (rd_en && sel_ram) begin
      mem_data_o = ram[ram_idx];
    end else if (rd_en && sel_io) begin
      case (io_off)
        OFF_LED:  mem_data_o = {22'd0, led_q};
        OFF_SW:   mem_data_o = {22'd0, sw_sync};
        OFF_CNT:  mem_data_o = cnt_q;
        OFF_CMP:  mem_data_o = cmp_q;
        OFF_CTRL: mem_data_o = {28'd0, ctrl_ie, ctrl_ar, ctrl_pend, ctrl_en};
        default:  mem_data_o = '0;
      endcase
    end
  end

  assign led_o       = led_q;
  assign timer_irq_o = ctrl_pend & ctrl_ie;

endmodule

// File: tb/tb_dbus_ram_io.sv
// Directed bench for dbus_ram_io: stimulus pushes expected values into a scoreboard,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_dbus_ram_io;

  localparam logic [31:0] A_LED  = 32'h4000_0000;
  localparam logic [31:0] A_SW   = 32'h4000_0004;
  localparam logic [31:0] A_CNT  = 32'h4000_0008;
  localparam logic [31:0] A_CMP  = 32'h4000_000C;
  localparam logic [31:0] A_CTRL = 32'h4000_0010;

  localparam int K_DATA = 0;
  localparam int K_LED  = 1;
  localparam int K_IRQ  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_sel;
  logic [9:0]  sw, led;
  logic        irq;

  always #5 clk = ~clk;

  dbus_ram_io #(.RAM_AW(10), .IO_BASE_HI(4'h4)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_ce_i    (mem_ce),
    .mem_we_i    (mem_we),
    .mem_addr_i  (mem_addr),
    .mem_sel_i   (mem_sel),
    .mem_data_i  (mem_wdata),
    .mem_data_o  (mem_rdata),
    .sw_i        (sw),
    .led_o       (led),
    .timer_irq_o (irq)
  );

  typedef struct {
    int          kind;
    logic [31:0] want;
    string       name;
  } chk_t;

  chk_t sbq[$];
  int   nchk = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic expect_out(input int kind, input logic [31:0] want, input string name);
    chk_t c;
    c.kind = kind;
    c.want = want;
    c.name = name;
    sbq.push_back(c);
    nchk++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    nchk      = 0;
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 4'h0;
    mem_wdata = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_addr  = a;
    mem_wdata = d;
    mem_sel   = s;
    mem_ce    = 1'b1;
    mem_we    = 1'b1;
    tick();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] want, input string name);
    mem_addr = a;
    mem_ce   = 1'b1;
    mem_we   = 1'b0;
    expect_out(K_DATA, want, name);
    tick();
  endtask

  always @(negedge clk) begin : monitor
    chk_t        c;
    logic [31:0] act;
    for (int i = 0; i < nchk; i++) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: no expected entry queued");
      end else begin
        c = sbq.pop_front();
        case (c.kind)
          K_LED:   act = {22'd0, led};
          K_IRQ:   act = {31'd0, irq};
          default: act = mem_rdata;
        endcase
        if (act !== c.want) begin
          errors++;
          $display("FAIL %s: got %08h expected %08h", c.name, act, c.want);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] seq [8];
    seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1};
    rst = 1'b0; sw = '0; mem_ce = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_sel = '0; mem_wdata = '0;
    tick();
    tick();
    rst = 1'b1;

    // Reset state
    expect_out(K_LED, 32'h0, "rst_led");
    expect_out(K_IRQ, 32'h0, "rst_irq");
    rd(A_CNT,  32'h0,         "rst_cnt");
    rd(A_CMP,  32'hFFFF_FFFF, "rst_cmp");
    rd(A_CTRL, 32'h0,         "rst_ctrl");
    rd(A_SW,   32'h0,         "rst_sw");

    // RAM byte lanes
    wr(32'h100, 32'h1122_3344, 4'b1111);
    wr(32'h100, 32'hAAAA_AAAA, 4'b0100);
    wr(32'h100, 32'hBEEF_BEEF, 4'b0011);
    rd(32'h100, 32'h11AA_BEEF, "ram_lanes");
    mem_addr = 32'h100;
    expect_out(K_DATA, 32'h0, "ram_ce0");
    tick();
    expect_out(K_DATA, 32'h0, "rdata_during_write");
    wr(32'h100, 32'h5555_5555, 4'b0000);
    rd(32'h100, 32'h11AA_BEEF, "ram_sel0_write");

    // Unmapped access
    wr(32'h0, 32'h0BAD_F00D, 4'b1111);
    wr(32'h8000_0000, 32'hDEAD_BEEF, 4'b1111);
    rd(32'h8000_0000, 32'h0, "unmapped_rd");
    rd(32'h0, 32'h0BAD_F00D, "ram0_intact");
    rd(32'h4000_0014, 32'h0, "io_off5");

    // Timer match with auto-reload
    wr(A_CMP,  32'd5,   4'b1111);
    wr(A_CTRL, 32'h0D,  4'b1111);
    for (int i = 0; i < 8; i++) begin
      expect_out(K_IRQ, (i >= 6) ? 32'd1 : 32'd0, $sformatf("irq_seq%0d", i));
      rd(A_CNT, seq[i], $sformatf("cnt_seq%0d", i));
    end
    expect_out(K_IRQ, 32'd1, "irq_before_clr");
    wr(A_CTRL, 32'h0F, 4'b1111);
    expect_out(K_IRQ, 32'd0, "irq_after_clr");
    rd(A_CNT, 32'd3, "cnt_after_clr");
    tick();
    // CNT==CMP in this cycle: clear collides with set
    wr(A_CTRL, 32'h0F, 4'b0001);
    expect_out(K_IRQ, 32'd1, "irq_collision");
    rd(A_CTRL, 32'h0F, "pend_collision");

    // CNT write vs increment
    wr(A_CTRL, 32'h02, 4'b0001);
    wr(A_CMP,  32'hFFFF_FFFF, 4'b1111);
    wr(A_CNT,  32'h0000_01FE, 4'b1111);
    wr(A_CTRL, 32'h01, 4'b0001);
    rd(A_CNT, 32'h0000_01FE, "cnt_start");
    wr(A_CNT, 32'h1010_1010, 4'b0001);
    rd(A_CNT, 32'h0000_0210, "cnt_wr_vs_inc");
    wr(A_CTRL, 32'h00, 4'b0001);
    rd(A_CNT, 32'h0000_0212, "cnt_stop");
    rd(A_CNT, 32'h0000_0212, "cnt_hold");

    // Switches and LEDs
    sw = 10'h2A5;
    tick();
    rd(A_SW, 32'h0,   "sw_sync1");
    rd(A_SW, 32'h2A5, "sw_sync2");
    wr(A_SW, 32'h0, 4'b1111);
    rd(A_SW, 32'h2A5, "sw_ro");
    wr(A_LED, 32'h3FF, 4'b1111);
    expect_out(K_LED, 32'h3FF, "led_o");
    rd(A_LED, 32'h3FF, "led_rd");

    // Reset mid-count with interrupt pending
    wr(A_CNT,  32'd0, 4'b1111);
    wr(A_CMP,  32'd2, 4'b1111);
    wr(A_CTRL, 32'h09, 4'b0001);
    tick();
    tick();
    tick();
    expect_out(K_IRQ, 32'd1, "irq_pre_rst");
    rst = 1'b0;
    tick();
    rst = 1'b1;
    expect_out(K_LED, 32'h0, "led_post_rst");
    expect_out(K_IRQ, 32'h0, "irq_post_rst");
    rd(A_CNT,  32'h0,         "cnt_post_rst");
    rd(A_CTRL, 32'h0,         "ctrl_post_rst");
    rd(A_CMP,  32'hFFFF_FFFF, "cmp_post_rst");
    rd(A_LED,  32'h0,         "ledreg_post_rst");

    tick();
    tick();
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
